// File: rtl/ghash_seq_pkg.sv
// ghash_seq_pkg: shared block width, default latencies and FSM state encoding for ghash_seq.
package ghash_seq_pkg;
    localparam int BLK_W = 128;
    localparam int MAT_LAT_DEF = 2;
    localparam int MUL_LAT_DEF = 2;
    typedef logic [BLK_W-1:0] blk_t;
    typedef enum logic [2:0] {IDLE, HWAIT, READY, MUL, DONE} state_e;
endpackage

// File: rtl/ghash_seq_if.sv
// ghash_seq_if: bundle of the ghash_seq control, block stream, result stream and external multiplier signals.
// Ports (master = environment side, slave = ghash_seq):
//   h_load/h, start            subkey load and message start strobes
//   in_valid/in_ready/in_data/in_last   128-bit block input stream
//   out_valid/out_ready/out_tag         128-bit tag output stream
//   mul_x/mul_y/mul_out        operands and result of the external GF(2^128) datapath
//   busy                       high outside IDLE and READY
interface ghash_seq_if;
    import ghash_seq_pkg::*;
    logic h_load;
    blk_t h;
    logic start;
    logic in_valid;
    logic in_ready;
    blk_t in_data;
    logic in_last;
    logic out_valid;
    logic out_ready;
    blk_t out_tag;
    blk_t mul_x;
    blk_t mul_y;
    blk_t mul_out;
    logic busy;
    modport master (
        output h_load, h, start, in_valid, in_data, in_last, out_ready, mul_out,
        input  in_ready, out_valid, out_tag, mul_x, mul_y, busy
    );
    modport slave (
        input  h_load, h, start, in_valid, in_data, in_last, out_ready, mul_out,
        output in_ready, out_valid, out_tag, mul_x, mul_y, busy
    );
endinterface

// File: rtl/ghash_seq.sv
// ghash_seq: GHASH sequencing FSM driving an external matrix_gen/compute GF(2^128) multiplier.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ghash_seq_if.slave: subkey load, start, block input stream, tag output stream,
//        multiplier operands mul_x (H) / mul_y (Y^block) and result mul_out, busy flag
// Parameters:
//   MAT_LAT  cycles after a new mul_x before the multiplier matrix is usable
//   MUL_LAT  cycles mul_y is driven before mul_out is sampled (0 behaves as 1)
module ghash_seq
    import ghash_seq_pkg::*;
#(
    parameter int MAT_LAT = MAT_LAT_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input logic      clk,
    input logic      rst,
    ghash_seq_if.slave bus
);
    localparam int MAT_EFF = (MAT_LAT < 1) ? 1 : MAT_LAT;
    localparam int MUL_EFF = (MUL_LAT < 1) ? 1 : MUL_LAT;
    localparam int CNT_MAX = (MAT_EFF > MUL_EFF) ? MAT_EFF : MUL_EFF;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MAT_CNT = CNT_W'(MAT_EFF);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             h_valid_q, h_valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    blk_t             y_q, y_d;
    blk_t             mul_x_q, mul_x_d;
    blk_t             mul_y_q, mul_y_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            h_valid_q <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            y_q       <= '0;
            mul_x_q   <= '0;
            mul_y_q   <= '0;
        end else begin
            state_q   <= state_d;
            h_valid_q <= h_valid_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            mul_x_q   <= mul_x_d;
            mul_y_q   <= mul_y_d;
        end
    end

    // Counters finish on the cycle they read 1, so a loaded value N spends exactly N cycles in the state.
    always_comb begin
        state_d   = state_q;
        h_valid_d = h_valid_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        mul_x_d   = mul_x_q;
        mul_y_d   = mul_y_q;
        case (state_q)
            IDLE: begin
                if (bus.h_load) begin
                    // The matrix is rebuilt from the new H, so the old one stops being usable.
                    mul_x_d   = bus.h;
                    cnt_d     = MAT_CNT;
                    h_valid_d = 1'b0;
                    state_d   = HWAIT;
                end else if (bus.start && h_valid_q) begin
                    y_d     = '0;
                    state_d = READY;
                end
            end
            HWAIT: begin
                if (cnt_q <= CNT_ONE) begin
                    cnt_d     = '0;
                    h_valid_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            READY: begin
                if (bus.in_valid) begin
                    mul_y_d = y_q ^ bus.in_data;
                    last_d  = bus.in_last;
                    cnt_d   = MUL_CNT;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (cnt_q <= CNT_ONE) begin
                    y_d     = bus.mul_out;
                    cnt_d   = '0;
                    state_d = last_q ? DONE : READY;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == READY);
        bus.out_valid = (state_q == DONE);
        bus.out_tag   = (state_q == DONE) ? y_q : '0;
        bus.busy      = !(state_q == IDLE || state_q == READY);
        bus.mul_x     = mul_x_q;
        bus.mul_y     = mul_y_q;
    end
endmodule

// File: tb/tb_ghash_seq.sv
// tb_ghash_seq: directed bench for ghash_seq with a delay-line multiplier stub (identity or real GF(2^128) product).
module tb_ghash_seq;
    import ghash_seq_pkg::*;

    localparam int ML = 2;
    localparam int MT = 2;
    localparam blk_t H1 = {8'h10, 120'h0};
    localparam blk_t TAG6 = {16'h3840, 112'h0};

    logic clk;
    logic rst;
    logic real_mul;
    blk_t stage0;
    blk_t mul_q;
    int checks;
    int errors;
    int n;

    ghash_seq_if bus ();

    ghash_seq #(.MAT_LAT(MT), .MUL_LAT(ML)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard GCM bit-reflected multiply: bit 127 of the integer is the x^0 coefficient.
    function automatic blk_t gf_mult(input blk_t x, input blk_t y);
        blk_t z;
        blk_t v;
        z = '0;
        v = y;
        for (int i = 127; i >= 0; i--) begin
            if (x[i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    // mul_out becomes valid in the MUL_LAT-th cycle that mul_y is driven (one register for ML=2).
    always_comb stage0 = real_mul ? gf_mult(bus.mul_y, bus.mul_x) : bus.mul_y;
    always_ff @(posedge clk) mul_q <= stage0;
    assign bus.mul_out = mul_q;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input blk_t obs, input blk_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_tag(input string tag);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            tick;
            n++;
        end
        chk(tag, blk_t'(n), blk_t'(ML + 1));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        real_mul = 1'b0;
        rst = 1'b1;
        bus.h_load = 1'b0;
        bus.h = '0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        tick;
        chk("rst_in_ready", blk_t'(bus.in_ready), 0);
        chk("rst_out_valid", blk_t'(bus.out_valid), 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_busy", blk_t'(bus.busy), 0);
        chk("rst_mul_x", bus.mul_x, 0);
        chk("rst_mul_y", bus.mul_y, 0);
        rst = 1'b0;
        tick;

        // start without a loaded H is ignored
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("s3_noh_ready", blk_t'(bus.in_ready), 0);
        chk("s3_noh_busy", blk_t'(bus.busy), 0);
        tick;
        chk("s3_noh_ready2", blk_t'(bus.in_ready), 0);
        bus.h = H1;
        bus.h_load = 1'b1;
        tick;
        bus.h_load = 1'b0;
        chk("s3_mul_x", bus.mul_x, H1);
        chk("s3_hwait_busy1", blk_t'(bus.busy), 1);
        tick;
        chk("s3_hwait_busy2", blk_t'(bus.busy), 1);
        tick;
        chk("s3_idle_busy", blk_t'(bus.busy), 0);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("s3_start_ready", blk_t'(bus.in_ready), 1);

        // single block, identity multiplier
        bus.in_valid = 1'b1;
        bus.in_data = 128'hA5;
        bus.in_last = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        chk("s1_mul_ready", blk_t'(bus.in_ready), 0);
        chk("s1_mul_y", bus.mul_y, 128'hA5);
        chk("s1_mul_busy", blk_t'(bus.busy), 1);
        wait_tag("s1_latency");
        chk("s1_tag", bus.out_tag, 128'hA5);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("s1_after_valid", blk_t'(bus.out_valid), 0);
        chk("s1_after_busy", blk_t'(bus.busy), 0);

        // three-block message, H kept from before
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("s2_ready", blk_t'(bus.in_ready), 1);
            bus.in_valid = 1'b1;
            bus.in_data = blk_t'(1) << k;
            bus.in_last = (k == 2);
            tick;
            bus.in_valid = 1'b0;
            for (int j = 0; j < ML; j++) begin
                chk("s2_busy_ready", blk_t'(bus.in_ready), 0);
                tick;
            end
        end
        chk("s2_valid", blk_t'(bus.out_valid), 1);
        chk("s2_tag", bus.out_tag, 128'h7);

        // backpressure in DONE, h_load ignored there
        bus.h = 128'hDEAD_BEEF;
        bus.h_load = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick;
            bus.h_load = 1'b0;
            chk("s4_valid", blk_t'(bus.out_valid), 1);
            chk("s4_tag", bus.out_tag, 128'h7);
            chk("s4_mul_x", bus.mul_x, H1);
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("s4_release", blk_t'(bus.busy), 0);

        // reset during the second block's multiply
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 128'h3;
        bus.in_last = 1'b0;
        tick;
        bus.in_valid = 1'b0;
        for (int j = 0; j < ML; j++) tick;
        chk("s5_ready2", blk_t'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data = 128'h5;
        bus.in_last = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        chk("s5_in_mul", blk_t'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("s5_rst_busy", blk_t'(bus.busy), 0);
        chk("s5_rst_mul_y", bus.mul_y, 0);
        chk("s5_rst_mul_x", bus.mul_x, 0);
        tick;
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk("s5_no_valid", blk_t'(bus.out_valid), 0);
            chk("s5_no_tag", bus.out_tag, 0);
            tick;
        end
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("s5_h_invalid", blk_t'(bus.in_ready), 0);

        // real GF multiply, single block 1 with H = x^3
        real_mul = 1'b1;
        bus.h = H1;
        bus.h_load = 1'b1;
        tick;
        bus.h_load = 1'b0;
        for (int j = 0; j < MT; j++) tick;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("s6_ready", blk_t'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data = 128'h1;
        bus.in_last = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        wait_tag("s6_latency");
        chk("s6_tag", bus.out_tag, TAG6);
        chk("s6_tag_model", bus.out_tag, gf_mult(128'h1, H1));
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("s6_done", blk_t'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
